ma_stage_ctrl: RTL and testbench
================================

Name: ma_stage_ctrl

Overview:
- Memory-access (MA) stage controller. It sits directly downstream of the EX/MA pipeline register and consumes its outputs.
- It issues loads and stores to data memory over a req/ack handshake and stalls the pipeline until the access completes.
- For stores it aligns write data and generates byte enables. For loads it extracts, sign- or zero-extends and registers the read data.
- It selects the write-back value and forwards it, with the destination register and write enable, towards the MA/WB register.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in BUSY waiting for DMEM_ACK before the access is aborted.
- TO_W, 5: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ALU_RESULT  in  32  effective address for loads/stores; ALU write-back value otherwise.
- STORE_DATA  in  32  rs2 value for stores.
- DEST_REG  in  5  destination register.
- PC_PLUS_4  in  32  link value.
- IMMEDIATE  in  32  immediate (LUI) value.
- MEM_WRITE  in  2  00 none, 01 byte, 10 half, 11 word.
- MEM_READ  in  2  00 none, 01 byte, 10 half, 11 word.
- LOAD_UNSIGNED  in  1  1 = zero-extend loads, 0 = sign-extend.
- REG_WRITE_SEL  in  2  00 ALU, 01 MEM, 10 PC_PLUS_4, 11 IMMEDIATE.
- REG_WRITE_ENABLE  in  1  write-back enable.
- DMEM_REQ  out  1  memory request, registered.
- DMEM_WE  out  1  1 = write, registered.
- DMEM_ADDR  out  32  word address {ALU_RESULT[31:2],2'b00}, registered.
- DMEM_BYTE_EN  out  4  byte lane enables, registered.
- DMEM_WDATA  out  32  lane-aligned store data, registered.
- DMEM_RDATA  in  32  read data, valid with DMEM_ACK.
- DMEM_ACK  in  1  one-cycle completion pulse.
- STALL  out  1  holds PC, IF/ID, ID/EX and EX/MA registers.
- WB_DATA  out  32  selected write-back value.
- WB_DEST_REG  out  5  DEST_REG passthrough.
- WB_REG_WRITE_ENABLE  out  1  qualified write enable.
- MISALIGNED  out  1  current access is misaligned.
- MEM_TIMEOUT  out  1  sticky timeout flag.

Behaviour:
- Reset:
  - Asynchronous on RESET high; state goes to IDLE.
  - DMEM_REQ=0, DMEM_WE=0, DMEM_ADDR=0, DMEM_BYTE_EN=0, DMEM_WDATA=0.
  - Load register = 0, timeout counter = 0, MEM_TIMEOUT=0.
  - STALL=0, WB_REG_WRITE_ENABLE=0.
  - Reset mid-access drops DMEM_REQ immediately; any late ACK arriving in IDLE is ignored.
- Access and misalignment:
  - access = (MEM_READ!=0) | (MEM_WRITE!=0); if both are nonzero, the read is ignored and the access is a store.
  - Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
- States:
  - IDLE: if access and not misaligned, STALL=1 (combinational) and next edge loads the DMEM_* registers, sets DMEM_REQ=1, clears the counter and moves to BUSY.
  - IDLE otherwise: STALL=0 and the instruction passes through in one cycle.
  - BUSY: STALL=1 and DMEM_* are held stable.
    - On DMEM_ACK: capture the extended load value, drop DMEM_REQ next edge, go to DONE.
    - If the counter reaches TIMEOUT_CYCLES without ACK: drop DMEM_REQ, set MEM_TIMEOUT, load register = 0, go to DONE.
    - ACK on the same cycle as the timeout takes priority over the timeout.
  - DONE: STALL=0 for exactly one cycle so EX/MA advances; then return to IDLE. Requests are never issued back-to-back without an intervening IDLE evaluation.
- Minimum load/store latency: 3 cycles (IDLE→BUSY, ACK in first BUSY cycle, DONE).
- Store byte lanes:
  - byte: BYTE_EN=1<<addr[1:0], WDATA = byte replicated ×4.
  - half: BYTE_EN = addr[1] ? 1100 : 0011, WDATA = half replicated ×2.
  - word: BYTE_EN=1111, WDATA=STORE_DATA.
- Load extraction: byte lane from addr[1:0], half lane from addr[1], then extend to 32 bits per LOAD_UNSIGNED. Word loads pass DMEM_RDATA unchanged.
- Write-back:
  - WB_DATA is a combinational mux on REG_WRITE_SEL; 01 selects the load register.
  - WB_REG_WRITE_ENABLE = REG_WRITE_ENABLE & ~STALL & ~(MISALIGNED trap) & (DEST_REG!=0).
- MEM_TIMEOUT is cleared only by RESET.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A misaligned access issues no request and causes no stall.
  - MISALIGNED=1 for that cycle and write-back is suppressed.
- MISALIGN_TRAP_EN undefined:
  - MISALIGNED is tied 0.
  - Addresses are forced aligned: half clears addr[0], word clears addr[1:0].
  - The access proceeds normally.

Test Plan:
- Reset during BUSY with DMEM_REQ=1 → DMEM_REQ=0, STALL=0 and state IDLE within the same cycle; a subsequent ACK produces no write-back.
- Word store, ALU_RESULT=0x104, STORE_DATA=0xDEADBEEF, ACK after 2 cycles:
  - DMEM_ADDR=0x104, BYTE_EN=1111, WE=1.
  - STALL high for 3 cycles, then low for 1.
- Byte load, addr 0x203, RDATA=0x80xxxxxx:
  - LOAD_UNSIGNED=0, REG_WRITE_SEL=01 → WB_DATA=0xFFFFFF80.
  - LOAD_UNSIGNED=1 → 0x00000080.
- Half store, addr 0x12, STORE_DATA=0x0000ABCD → BYTE_EN=1100, WDATA=0xABCDABCD.
- No ACK → DMEM_REQ drops after 16 BUSY cycles, MEM_TIMEOUT=1, WB_DATA=0 for a MEM-select load, pipeline resumes.
- Word load at 0x102:
  - With MISALIGN_TRAP_EN: MISALIGNED=1, DMEM_REQ stays 0, WB_REG_WRITE_ENABLE=0.
  - Without it: DMEM_ADDR=0x100.

Source files
------------

// File: rtl/ma_stage_ctrl.sv
// Memory-access stage controller: issues DMEM loads/stores, aligns store data, extends load data, selects write-back.
// Latency: pass-through in 1 cycle without an access; loads/stores take at least 3 cycles (IDLE -> BUSY -> DONE).
// Backpressure: holds STALL high until DMEM_ACK or the BUSY timeout, then releases it for one DONE cycle.
// Build option: define MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing them aligned.
module ma_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] STORE_DATA,
  input  logic [4:0]  DEST_REG,
  input  logic [31:0] PC_PLUS_4,
  input  logic [31:0] IMMEDIATE,
  input  logic [1:0]  MEM_WRITE,
  input  logic [1:0]  MEM_READ,
  input  logic        LOAD_UNSIGNED,
  input  logic [1:0]  REG_WRITE_SEL,
  input  logic        REG_WRITE_ENABLE,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BYTE_EN,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        STALL,
  output logic [31:0] WB_DATA,
  output logic [4:0]  WB_DEST_REG,
  output logic        WB_REG_WRITE_ENABLE,
  output logic        MISALIGNED,
  output logic        MEM_TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Everything presented on the data-memory port, registered as one bundle.
  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
  } dmem_req_t;

  state_t          state_q, state_d;
  dmem_req_t       dmem_q, dmem_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     load_q, load_d;
  logic            timeout_q, timeout_d;

  logic        is_store;
  logic        is_load;
  logic        access;
  logic [1:0]  size;
  logic [1:0]  lo;          // low address bits actually used for lane selection
  logic        misaligned;
  logic        stall_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;

  // A store wins when both read and write are requested; the read is dropped.
  assign is_store = (MEM_WRITE != 2'b00);
  assign is_load  = (MEM_READ != 2'b00) & ~is_store;
  assign access   = is_store | is_load;
  assign size     = is_store ? MEM_WRITE : MEM_READ;

`ifdef MISALIGN_TRAP_EN
  assign lo         = ALU_RESULT[1:0];
  assign misaligned = (state_q == S_IDLE) & access &
                      (((size == 2'b10) & ALU_RESULT[0]) |
                       ((size == 2'b11) & (ALU_RESULT[1:0] != 2'b00)));
`else
  // Without the trap, halves drop addr[0] and words drop addr[1:0].
  assign lo         = (size == 2'b11) ? 2'b00 :
                      (size == 2'b10) ? {ALU_RESULT[1], 1'b0} : ALU_RESULT[1:0];
  assign misaligned = 1'b0;
`endif

  // Store lane enables and lane-replicated write data.
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = 32'h0;
    case (size)
      2'b01: begin
        be_c    = 4'b0001 << lo;
        wdata_c = {4{STORE_DATA[7:0]}};
      end
      2'b10: begin
        be_c    = lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{STORE_DATA[15:0]}};
      end
      2'b11: begin
        be_c    = 4'b1111;
        wdata_c = STORE_DATA;
      end
      default: begin
        be_c    = 4'b0000;
        wdata_c = 32'h0;
      end
    endcase
    if (!is_store) begin
      wdata_c = 32'h0;
    end
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    byte_v = 8'h00;
    case (lo)
      2'b00:   byte_v = DMEM_RDATA[7:0];
      2'b01:   byte_v = DMEM_RDATA[15:8];
      2'b10:   byte_v = DMEM_RDATA[23:16];
      default: byte_v = DMEM_RDATA[31:24];
    endcase
    half_v   = lo[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    load_ext = DMEM_RDATA;
    case (MEM_READ)
      2'b01:   load_ext = LOAD_UNSIGNED ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b10:   load_ext = LOAD_UNSIGNED ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_ext = DMEM_RDATA;
    endcase
  end

  // Next-state and stall logic for the IDLE/BUSY/DONE access sequence.
  always_comb begin
    state_d   = state_q;
    dmem_d    = dmem_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    timeout_d = timeout_q;
    stall_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && !misaligned) begin
          stall_c        = 1'b1;
          state_d        = S_BUSY;
          dmem_d.req     = 1'b1;
          dmem_d.we      = is_store;
          dmem_d.addr    = {ALU_RESULT[31:2], 2'b00};
          dmem_d.byte_en = be_c;
          dmem_d.wdata   = wdata_c;
          cnt_d          = '0;
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        // A completion in the final waiting cycle beats the timeout.
        if (DMEM_ACK) begin
          if (is_load) begin
            load_d = load_ext;
          end
          dmem_d.req = 1'b0;
          state_d    = S_DONE;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          dmem_d.req = 1'b0;
          timeout_d  = 1'b1;
          load_d     = 32'h0;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, DMEM bundle, timeout counter, load register and sticky timeout flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      dmem_q    <= '0;
      cnt_q     <= '0;
      load_q    <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dmem_q    <= dmem_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      timeout_q <= timeout_d;
    end
  end

  // Write-back value selection.
  always_comb begin
    WB_DATA = ALU_RESULT;
    case (REG_WRITE_SEL)
      2'b00:   WB_DATA = ALU_RESULT;
      2'b01:   WB_DATA = load_q;
      2'b10:   WB_DATA = PC_PLUS_4;
      default: WB_DATA = IMMEDIATE;
    endcase
  end

  // Reset forces the pipeline to run free and suppresses write-back at once.
  assign STALL               = stall_c & ~RESET;
  assign WB_DEST_REG         = DEST_REG;
  assign WB_REG_WRITE_ENABLE = REG_WRITE_ENABLE & ~stall_c & ~misaligned &
                               (DEST_REG != 5'd0) & ~RESET;
  assign MISALIGNED          = misaligned;
  assign MEM_TIMEOUT         = timeout_q;

  assign DMEM_REQ     = dmem_q.req;
  assign DMEM_WE      = dmem_q.we;
  assign DMEM_ADDR    = dmem_q.addr;
  assign DMEM_BYTE_EN = dmem_q.byte_en;
  assign DMEM_WDATA   = dmem_q.wdata;

endmodule

// File: tb/tb_ma_stage_ctrl.sv
// Bench for ma_stage_ctrl: directed vector tables plus hand sequences for timeout, misalignment and reset.
// Latency: drives inputs 1 time unit after the rising edge, samples 2 units later.
// Backpressure: waits on STALL/DMEM_REQ are bounded by cycle budgets.
module tb_ma_stage_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ALU_RESULT, STORE_DATA, PC_PLUS_4, IMMEDIATE;
  logic [4:0]  DEST_REG;
  logic [1:0]  MEM_WRITE, MEM_READ, REG_WRITE_SEL;
  logic        LOAD_UNSIGNED, REG_WRITE_ENABLE;
  logic        DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic        DMEM_ACK;
  logic        STALL;
  logic [31:0] WB_DATA;
  logic [4:0]  WB_DEST_REG;
  logic        WB_REG_WRITE_ENABLE, MISALIGNED, MEM_TIMEOUT;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  ma_stage_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .ALU_RESULT(ALU_RESULT), .STORE_DATA(STORE_DATA), .DEST_REG(DEST_REG),
    .PC_PLUS_4(PC_PLUS_4), .IMMEDIATE(IMMEDIATE),
    .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ), .LOAD_UNSIGNED(LOAD_UNSIGNED),
    .REG_WRITE_SEL(REG_WRITE_SEL), .REG_WRITE_ENABLE(REG_WRITE_ENABLE),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_BYTE_EN(DMEM_BYTE_EN), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .STALL(STALL), .WB_DATA(WB_DATA), .WB_DEST_REG(WB_DEST_REG),
    .WB_REG_WRITE_ENABLE(WB_REG_WRITE_ENABLE), .MISALIGNED(MISALIGNED),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  );

  typedef struct {
    string       name;
    logic [31:0] alu, pc4, imm;
    logic [1:0]  sel;
    logic        rwe;
    logic [4:0]  dest;
    logic [31:0] e_wb;
    logic        e_en;
  } pt_t;

  typedef struct {
    string       name;
    logic [31:0] alu, sdat, rdata;
    logic [1:0]  mw, mr, sel;
    logic        uns, rwe;
    logic [4:0]  dest;
    int          ack_wait;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata, e_wb;
    logic        e_en;
  } acc_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_idle();
    ALU_RESULT = 32'h0; STORE_DATA = 32'h0; PC_PLUS_4 = 32'h0; IMMEDIATE = 32'h0;
    DEST_REG = 5'd0; MEM_WRITE = 2'b00; MEM_READ = 2'b00; LOAD_UNSIGNED = 1'b0;
    REG_WRITE_SEL = 2'b00; REG_WRITE_ENABLE = 1'b0;
  endtask

  function automatic acc_t mk(input string name, input logic [31:0] alu, input logic [31:0] sdat,
                              input logic [31:0] rdata, input logic [1:0] mw, input logic [1:0] mr,
                              input logic uns, input logic [1:0] sel, input logic rwe,
                              input logic [4:0] dest, input int ack_wait, input logic [31:0] e_addr,
                              input logic [3:0] e_be, input logic e_we, input logic [31:0] e_wdata,
                              input logic [31:0] e_wb, input logic e_en);
    acc_t a;
    a.name = name; a.alu = alu; a.sdat = sdat; a.rdata = rdata; a.mw = mw; a.mr = mr;
    a.uns = uns; a.sel = sel; a.rwe = rwe; a.dest = dest; a.ack_wait = ack_wait;
    a.e_addr = e_addr; a.e_be = e_be; a.e_we = e_we; a.e_wdata = e_wdata;
    a.e_wb = e_wb; a.e_en = e_en;
    return a;
  endfunction

  // Full handshake for one access; starts and ends 1 unit after an edge in IDLE.
  task automatic run_access(input acc_t v);
    ALU_RESULT = v.alu; STORE_DATA = v.sdat; MEM_WRITE = v.mw; MEM_READ = v.mr;
    LOAD_UNSIGNED = v.uns; REG_WRITE_SEL = v.sel; REG_WRITE_ENABLE = v.rwe; DEST_REG = v.dest;
    PC_PLUS_4 = 32'h0; IMMEDIATE = 32'h0;
    settle();
    chk({v.name, " idle_stall"}, 32'(STALL), 32'd1);
    chk({v.name, " idle_misal"}, 32'(MISALIGNED), 32'd0);
    chk({v.name, " idle_wben"}, 32'(WB_REG_WRITE_ENABLE), 32'd0);
    tick(); settle();
    chk({v.name, " req"}, 32'(DMEM_REQ), 32'd1);
    chk({v.name, " we"}, 32'(DMEM_WE), 32'(v.e_we));
    chk({v.name, " addr"}, DMEM_ADDR, v.e_addr);
    chk({v.name, " busy_stall"}, 32'(STALL), 32'd1);
    if (v.mw != 2'b00) begin
      chk({v.name, " byte_en"}, 32'(DMEM_BYTE_EN), 32'(v.e_be));
      chk({v.name, " wdata"}, DMEM_WDATA, v.e_wdata);
    end
    for (int i = 0; i < v.ack_wait; i++) begin
      tick(); settle();
      chk({v.name, " wait_stall"}, 32'(STALL), 32'd1);
      chk({v.name, " wait_req"}, 32'(DMEM_REQ), 32'd1);
    end
    DMEM_ACK = 1'b1; DMEM_RDATA = v.rdata;
    tick();
    DMEM_ACK = 1'b0; DMEM_RDATA = 32'h5A5A5A5A;
    settle();
    chk({v.name, " done_stall"}, 32'(STALL), 32'd0);
    chk({v.name, " done_req"}, 32'(DMEM_REQ), 32'd0);
    chk({v.name, " wb_data"}, WB_DATA, v.e_wb);
    chk({v.name, " wb_en"}, 32'(WB_REG_WRITE_ENABLE), 32'(v.e_en));
    chk({v.name, " wb_dest"}, 32'(WB_DEST_REG), 32'(v.dest));
    tick();
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pt_t  ptab[$];
    acc_t atab[$];
    pt_t  p;
    int   cyc;

    ptab.push_back('{"pt_alu", 32'h11111111, 32'h00001004, 32'hABCD0000, 2'b00, 1'b1, 5'd3, 32'h11111111, 1'b1});
    ptab.push_back('{"pt_pc4", 32'h11111111, 32'h00001004, 32'hABCD0000, 2'b10, 1'b1, 5'd4, 32'h00001004, 1'b1});
    ptab.push_back('{"pt_imm", 32'h11111111, 32'h00001004, 32'hABCD0000, 2'b11, 1'b1, 5'd31, 32'hABCD0000, 1'b1});
    ptab.push_back('{"pt_mem", 32'h11111111, 32'h00001004, 32'hABCD0000, 2'b01, 1'b1, 5'd6, 32'h00000000, 1'b1});
    ptab.push_back('{"pt_nowe", 32'h22222222, 32'h0, 32'h0, 2'b00, 1'b0, 5'd7, 32'h22222222, 1'b0});
    ptab.push_back('{"pt_x0", 32'h33333333, 32'h0, 32'h0, 2'b00, 1'b1, 5'd0, 32'h33333333, 1'b0});

    //                name         alu           sdat          rdata         mw     mr     uns   sel    rwe   dst  w  e_addr        e_be     we    e_wdata       e_wb          en
    atab.push_back(mk("sw_104",    32'h00000104, 32'hDEADBEEF, 32'h0,        2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0, 1, 32'h00000104, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h00000104, 1'b0));
    atab.push_back(mk("lb_s_203",  32'h00000203, 32'h0,        32'h80123456, 2'b00, 2'b01, 1'b0, 2'b01, 1'b1, 5'd5, 0, 32'h00000200, 4'b0000, 1'b0, 32'h0,        32'hFFFFFF80, 1'b1));
    atab.push_back(mk("lb_u_203",  32'h00000203, 32'h0,        32'h80123456, 2'b00, 2'b01, 1'b1, 2'b01, 1'b1, 5'd5, 0, 32'h00000200, 4'b0000, 1'b0, 32'h0,        32'h00000080, 1'b1));
    atab.push_back(mk("sh_12",     32'h00000012, 32'h0000ABCD, 32'h0,        2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0, 0, 32'h00000010, 4'b1100, 1'b1, 32'hABCDABCD, 32'h00000012, 1'b0));
    atab.push_back(mk("sb_101",    32'h00000101, 32'h000000A5, 32'h0,        2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0, 2, 32'h00000100, 4'b0010, 1'b1, 32'hA5A5A5A5, 32'h00000101, 1'b0));
    atab.push_back(mk("lh_s_22",   32'h00000022, 32'h0,        32'h80011234, 2'b00, 2'b10, 1'b0, 2'b01, 1'b1, 5'd8, 0, 32'h00000020, 4'b0000, 1'b0, 32'h0,        32'hFFFF8001, 1'b1));
    atab.push_back(mk("lh_u_20",   32'h00000020, 32'h0,        32'h1234F00D, 2'b00, 2'b10, 1'b1, 2'b01, 1'b1, 5'd8, 1, 32'h00000020, 4'b0000, 1'b0, 32'h0,        32'h0000F00D, 1'b1));
    atab.push_back(mk("lw_40_x0",  32'h00000040, 32'h0,        32'hCAFEF00D, 2'b00, 2'b11, 1'b0, 2'b01, 1'b1, 5'd0, 0, 32'h00000040, 4'b0000, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0));
    atab.push_back(mk("sw_rd_80",  32'h00000080, 32'h11223344, 32'h0,        2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 5'd0, 0, 32'h00000080, 4'b1111, 1'b1, 32'h11223344, 32'h00000080, 1'b0));
    atab.push_back(mk("lb_s_201",  32'h00000201, 32'h0,        32'h00007F00, 2'b00, 2'b01, 1'b0, 2'b01, 1'b1, 5'd9, 0, 32'h00000200, 4'b0000, 1'b0, 32'h0,        32'h0000007F, 1'b1));
`ifndef MISALIGN_TRAP_EN
    atab.push_back(mk("lw_102_frc", 32'h00000102, 32'h0,       32'h13579BDF, 2'b00, 2'b11, 1'b0, 2'b01, 1'b1, 5'd9, 0, 32'h00000100, 4'b0000, 1'b0, 32'h0,        32'h13579BDF, 1'b1));
    atab.push_back(mk("sh_13_frc", 32'h00000013, 32'h00001234, 32'h0,        2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 5'd0, 0, 32'h00000010, 4'b1100, 1'b1, 32'h12341234, 32'h00000013, 1'b0));
`endif

    // Reset: outputs cleared, stall and write-back gated even with a pending load presented.
    DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
    set_idle();
    RESET = 1'b1;
    MEM_READ = 2'b11; REG_WRITE_ENABLE = 1'b1; DEST_REG = 5'd1;
    #3;
    chk("rst_req", 32'(DMEM_REQ), 32'd0);
    chk("rst_we", 32'(DMEM_WE), 32'd0);
    chk("rst_addr", DMEM_ADDR, 32'h0);
    chk("rst_be", 32'(DMEM_BYTE_EN), 32'd0);
    chk("rst_wdata", DMEM_WDATA, 32'h0);
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_wben", 32'(WB_REG_WRITE_ENABLE), 32'd0);
    chk("rst_timeout", 32'(MEM_TIMEOUT), 32'd0);
    tick(); tick();
    set_idle();
    RESET = 1'b0;
    tick();

    // Pass-through vectors with no memory access.
    foreach (ptab[i]) begin
      p = ptab[i];
      ALU_RESULT = p.alu; PC_PLUS_4 = p.pc4; IMMEDIATE = p.imm;
      REG_WRITE_SEL = p.sel; REG_WRITE_ENABLE = p.rwe; DEST_REG = p.dest;
      settle();
      chk({p.name, " stall"}, 32'(STALL), 32'd0);
      chk({p.name, " wb_data"}, WB_DATA, p.e_wb);
      chk({p.name, " wb_en"}, 32'(WB_REG_WRITE_ENABLE), 32'(p.e_en));
      chk({p.name, " wb_dest"}, 32'(WB_DEST_REG), 32'(p.dest));
      tick();
    end
    set_idle();
    tick();

    // Load/store handshakes.
    foreach (atab[i]) begin
      run_access(atab[i]);
    end

    // No ACK: request held for 16 BUSY cycles, then sticky timeout and a zero load value.
    ALU_RESULT = 32'h00000300; MEM_READ = 2'b11; REG_WRITE_SEL = 2'b01;
    REG_WRITE_ENABLE = 1'b1; DEST_REG = 5'd7;
    tick(); settle();
    cyc = 0;
    while (DMEM_REQ === 1'b1 && cyc < 40) begin
      cyc++;
      chk("to_busy_stall", 32'(STALL), 32'd1);
      tick(); settle();
    end
    chk("to_busy_cycles", 32'(cyc), 32'd16);
    chk("to_req", 32'(DMEM_REQ), 32'd0);
    chk("to_flag", 32'(MEM_TIMEOUT), 32'd1);
    chk("to_stall", 32'(STALL), 32'd0);
    chk("to_wb_data", WB_DATA, 32'h0);
    tick();
    set_idle();
    settle();
    chk("to_sticky", 32'(MEM_TIMEOUT), 32'd1);
    chk("to_resume_stall", 32'(STALL), 32'd0);
    tick();

`ifdef MISALIGN_TRAP_EN
    // Misaligned word load traps: no request, no stall, no write-back.
    ALU_RESULT = 32'h00000102; MEM_READ = 2'b11; REG_WRITE_SEL = 2'b01;
    REG_WRITE_ENABLE = 1'b1; DEST_REG = 5'd4;
    settle();
    chk("mis_flag", 32'(MISALIGNED), 32'd1);
    chk("mis_stall", 32'(STALL), 32'd0);
    chk("mis_wben", 32'(WB_REG_WRITE_ENABLE), 32'd0);
    tick(); settle();
    chk("mis_req", 32'(DMEM_REQ), 32'd0);
    tick();
    set_idle();
    tick();
`endif

    // Reset in the middle of BUSY, then a late ACK must be ignored.
    ALU_RESULT = 32'h00000500; MEM_READ = 2'b11; REG_WRITE_SEL = 2'b01;
    REG_WRITE_ENABLE = 1'b1; DEST_REG = 5'd2;
    tick(); settle();
    chk("mid_pre_req", 32'(DMEM_REQ), 32'd1);
    RESET = 1'b1;
    #1;
    chk("mid_req", 32'(DMEM_REQ), 32'd0);
    chk("mid_stall", 32'(STALL), 32'd0);
    chk("mid_timeout", 32'(MEM_TIMEOUT), 32'd0);
    set_idle();
    REG_WRITE_SEL = 2'b01;
    #1;
    RESET = 1'b0;
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hFEEDFACE;
    tick();
    DMEM_ACK = 1'b0;
    settle();
    chk("late_ack_wb", WB_DATA, 32'h0);
    chk("late_ack_req", 32'(DMEM_REQ), 32'd0);
    chk("late_ack_stall", 32'(STALL), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
